// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Front-end fetch stage of the single-issue RISC-V pipeline. Owns the PC, drives the
// word-addressed instruction memory (combinational read) and registers the returned word
// into IF/ID. Handles stall, redirect with flush of the wrong-path slot, and a sticky
// fault for misaligned redirect targets or out-of-range fetch addresses.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word-aligned)
//   MEM_WORDS  number of 32-bit words in instruction memory
// Ports:
//   Clock, Reset      clock and asynchronous active-high reset
//   Inst_Address      current PC to instruction memory
//   Mem_Instruction   instruction word for Inst_Address, same cycle
//   Stall             hold PC and IF/ID
//   Redirect          taken branch/jump; Redirect_Target is the new PC
//   ID_Instruction    IF/ID instruction register
//   ID_PC             address of ID_Instruction
//   ID_Valid          1 = real instruction, 0 = bubble
//   Fault, Fault_PC   sticky fetch fault and the offending address
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] Inst_Address,
  input  logic [31:0] Mem_Instruction,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] ID_Instruction,
  output logic [31:0] ID_PC,
  output logic        ID_Valid,
  output logic        Fault,
  output logic [31:0] Fault_PC
);

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StFault
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_valid;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  state_e      w_state_d;
  logic [31:0] w_pc_d;
  logic [31:0] w_id_instr_d;
  logic [31:0] w_id_pc_d;
  logic        w_id_valid_d;
  logic        w_fault_d;
  logic [31:0] w_fault_pc_d;

  logic [31:0] w_word_idx;
  logic        w_out_of_range;

  assign w_word_idx     = {2'b00, r_pc[31:2]};
  assign w_out_of_range = (w_word_idx >= 32'(MEM_WORDS));

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_id_instr_d = r_id_instr;
    w_id_pc_d    = r_id_pc;
    w_id_valid_d = r_id_valid;
    w_fault_d    = r_fault;
    w_fault_pc_d = r_fault_pc;

    unique case (r_state)
      StBoot: begin
        // Single settling cycle; stall and redirect are deliberately ignored here.
        w_id_valid_d = 1'b0;
        w_state_d    = StFetch;
      end
      StFetch: begin
        if (Redirect && (Redirect_Target[1:0] != 2'b00)) begin
          w_state_d    = StFault;
          w_fault_d    = 1'b1;
          w_fault_pc_d = Redirect_Target;
          w_id_valid_d = 1'b0;
        end else if (Redirect) begin
          // Flush the wrong-path slot; target is range-checked when it is fetched.
          w_pc_d       = Redirect_Target;
          w_id_valid_d = 1'b0;
        end else if (Stall) begin
          // Everything holds (defaults).
        end else if (w_out_of_range) begin
          w_state_d    = StFault;
          w_fault_d    = 1'b1;
          w_fault_pc_d = r_pc;
          w_id_valid_d = 1'b0;
        end else begin
          w_id_instr_d = Mem_Instruction;
          w_id_pc_d    = r_pc;
          w_id_valid_d = 1'b1;
          w_pc_d       = r_pc + 32'd4;
        end
      end
      StFault: begin
        w_id_valid_d = 1'b0;
      end
      default: begin
        w_state_d    = StFault;
        w_id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC;
      r_id_instr <= NopInstr;
      r_id_pc    <= 32'h0;
      r_id_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_id_instr <= w_id_instr_d;
      r_id_pc    <= w_id_pc_d;
      r_id_valid <= w_id_valid_d;
      r_fault    <= w_fault_d;
      r_fault_pc <= w_fault_pc_d;
    end
  end

  assign Inst_Address   = r_pc;
  assign ID_Instruction = r_id_instr;
  assign ID_PC          = r_id_pc;
  assign ID_Valid       = r_id_valid;
  assign Fault          = r_fault;
  assign Fault_PC       = r_fault_pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit (MEM_WORDS = 8, RESET_PC = 0).
module tb_instruction_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic [31:0] Inst_Address;
  logic [31:0] Mem_Instruction;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic [31:0] ID_Instruction;
  logic [31:0] ID_PC;
  logic        ID_Valid;
  logic        Fault;
  logic [31:0] Fault_PC;

  int checks = 0;
  int failures = 0;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(8)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Inst_Address   (Inst_Address),
    .Mem_Instruction(Mem_Instruction),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .Redirect_Target(Redirect_Target),
    .ID_Instruction (ID_Instruction),
    .ID_PC          (ID_PC),
    .ID_Valid       (ID_Valid),
    .Fault          (Fault),
    .Fault_PC       (Fault_PC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory image: word i holds 32'hC0DE_0000 + i; beyond 16 words returns a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr[31:2] < 30'd16) return 32'hC0DE_0000 + {2'b00, addr[31:2]};
    return 32'hDEAD_BEEF;
  endfunction

  always_comb Mem_Instruction = mem_word(Inst_Address);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] idpc, input logic valid, input logic flt,
                           input logic [31:0] fpc);
    check({tag, ".pc"}, Inst_Address, pc);
    check({tag, ".instr"}, ID_Instruction, instr);
    check({tag, ".idpc"}, ID_PC, idpc);
    check({tag, ".valid"}, {31'b0, ID_Valid}, {31'b0, valid});
    check({tag, ".fault"}, {31'b0, Fault}, {31'b0, flt});
    check({tag, ".fpc"}, Fault_PC, fpc);
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    Redirect = 1'b0;
    Redirect_Target = 32'h0;
    #2;
    check_all("reset", 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    Reset = 1'b0;
    // BOOT ignores stall and redirect
    Stall = 1'b1;
    Redirect = 1'b1;
    Redirect_Target = 32'h40;
    tick();
    check_all("boot", 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
    Stall = 1'b0;
    Redirect = 1'b0;
    tick();
    check_all("e2", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_all("e3", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 1'b0, 32'h0);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 1'b0, 32'h0);
    end
    Stall = 1'b0;
    tick();
    check_all("unstall", 32'hC, 32'hC0DE_0002, 32'h8, 1'b1, 1'b0, 32'h0);
    // Redirect overrides stall
    Stall = 1'b1;
    Redirect = 1'b1;
    Redirect_Target = 32'h10;
    tick();
    check_all("redir", 32'h10, 32'hC0DE_0002, 32'h8, 1'b0, 1'b0, 32'h0);
    Stall = 1'b0;
    Redirect = 1'b0;
    tick();
    check_all("target", 32'h14, 32'hC0DE_0004, 32'h10, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    tick();
    check_all("last", 32'h20, 32'hC0DE_0007, 32'h1C, 1'b1, 1'b0, 32'h0);
    // PC 0x20 is word 8 >= MEM_WORDS
    tick();
    check_all("range", 32'h20, 32'hC0DE_0007, 32'h1C, 1'b0, 1'b1, 32'h20);
    Redirect = 1'b1;
    Redirect_Target = 32'h4;
    Stall = 1'b1;
    tick();
    tick();
    check_all("fault_hold", 32'h20, 32'hC0DE_0007, 32'h1C, 1'b0, 1'b1, 32'h20);
    Redirect = 1'b0;
    Stall = 1'b0;

    // Reset out of FAULT, run until valid, then reset mid-cycle
    Reset = 1'b1;
    #1;
    check_all("rst_fault", 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check_all("r2_e2", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    check_all("r2_e3", 32'h8, 32'hC0DE_0001, 32'h4, 1'b1, 1'b0, 32'h0);
    Reset = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h13, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check_all("r3_e2", 32'h4, 32'hC0DE_0000, 32'h0, 1'b1, 1'b0, 32'h0);
    // Misaligned redirect target
    Redirect = 1'b1;
    Redirect_Target = 32'h6;
    tick();
    check_all("misalign", 32'h4, 32'hC0DE_0000, 32'h0, 1'b0, 1'b1, 32'h6);
    Redirect_Target = 32'h8;
    Stall = 1'b1;
    tick();
    tick();
    check_all("mis_hold", 32'h4, 32'hC0DE_0000, 32'h0, 1'b0, 1'b1, 32'h6);
    Redirect = 1'b0;
    Stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
